// File: rtl/stream_merge_2x1.sv
// Two-input packet-aware stream merger: round-robin grant held for a whole
// packet, steering a 2:1 select into a registered valid/ready output stage.
module stream_merge_2x1 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               out_src_q, out_src_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

  logic               grant0, grant1;
  logic               sel;
  logic               load_ok;
  logic               xfer;
  logic [WIDTH-1:0]   mux_data;
  logic               mux_last;

  // In IDLE the grant follows the live valids; on contention the channel
  // that did not most recently finish a packet wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state_q)
      LOCK0: grant0 = 1'b1;
      LOCK1: grant1 = 1'b1;
      default: begin
        if (in0_valid && in1_valid) begin
          grant0 = last_grant_q;
          grant1 = !last_grant_q;
        end else begin
          grant0 = in0_valid;
          grant1 = in1_valid;
        end
      end
    endcase
  end

  assign sel      = grant1;
  // rst_n gates the readies so nothing looks accepted while reset is held.
  assign load_ok  = rst_n && (!out_valid_q || out_ready);
  assign in0_ready = grant0 && load_ok;
  assign in1_ready = grant1 && load_ok;
  assign xfer     = (in0_valid && in0_ready) || (in1_valid && in1_ready);
  assign mux_data = sel ? in1_data : in0_data;
  assign mux_last = sel ? in1_last : in0_last;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pkt_cnt_d    = pkt_cnt_q;
    if (xfer) begin
      if (mux_last) begin
        state_d      = IDLE;
        last_grant_d = sel;
        pkt_cnt_d    = pkt_cnt_q + CNT_W'(1);
      end else begin
        state_d = sel ? LOCK1 : LOCK0;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_last_d  = mux_last;
      out_src_d   = sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_src_q    <= 1'b0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_src_q    <= out_src_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_stream_merge_2x1.sv
// Bench for stream_merge_2x1: vector table, hand-written corner sequences and
// a randomized run against a transaction-level reference model.
module tb_stream_merge_2x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in0_valid, in0_last, in0_ready;
  logic [7:0] in0_data;
  logic       in1_valid, in1_last, in1_ready;
  logic [7:0] in1_data;
  logic       out_valid, out_last, out_src, out_ready;
  logic [7:0] out_data;
  logic [15:0] pkt_cnt;

  logic       w0_valid, w0_last, w0_ready;
  logic [7:0] w0_data;
  logic       w1_ready, w_out_valid, w_out_last, w_out_src;
  logic [7:0] w_out_data;
  logic [3:0] w_pkt_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_merge_2x1 #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .pkt_cnt(pkt_cnt)
  );

  stream_merge_2x1 #(.WIDTH(8), .CNT_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(w0_valid), .in0_data(w0_data), .in0_last(w0_last), .in0_ready(w0_ready),
    .in1_valid(1'b0), .in1_data(8'h00), .in1_last(1'b0), .in1_ready(w1_ready),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_last(w_out_last), .out_src(w_out_src),
    .out_ready(1'b1), .pkt_cnt(w_pkt_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic v0; logic [7:0] d0; logic l0;
    logic v1; logic [7:0] d1; logic l1;
    logic ordy;
    logic r0; logic r1;
    logic ov; logic [7:0] od; logic ol; logic os; logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic v0, logic [7:0] d0, logic l0, logic v1, logic [7:0] d1,
                              logic l1, logic ordy, logic r0, logic r1, logic ov,
                              logic [7:0] od, logic ol, logic os, logic [15:0] cnt);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1; v.ordy = ordy;
    v.r0 = r0; v.r1 = r1; v.ov = ov; v.od = od; v.ol = ol; v.os = os; v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1, input logic ordy);
    in0_valid = v0; in0_data = d0; in0_last = l0;
    in1_valid = v1; in1_data = d1; in1_last = l1;
    out_ready = ordy;
  endtask

  // Reference model state: packet owner (-1 when none open), round-robin pointer,
  // output register image and packet count.
  int          m_owner;
  logic        m_rr;
  logic        m_ov, m_ol, m_os;
  logic [7:0]  m_od;
  logic [15:0] m_cnt;

  logic        pv[2], pl[2];
  logic [7:0]  pd[2];
  int          prem[2];

  vec_t tbl[19];

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
    w0_valid = 1'b0; w0_data = '0; w0_last = 1'b0;
    #1;
    chk("reset_rdy0", in0_ready, 0);
    chk("reset_rdy1", in1_ready, 0);
    chk("reset_ov", out_valid, 0);
    chk("reset_cnt", pkt_cnt, 0);
    chk("reset_od", out_data, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //            v0  d0    l0  v1  d1    l1  or  r0  r1  ov  od    ol  os  cnt
    tbl[0]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 1,  0,  0,  0, 8'h00, 0, 0, 0);
    tbl[1]  = mk(1, 8'h3C, 1, 0, 8'h00, 0, 1,  1,  0,  1, 8'h3C, 1, 0, 1);
    tbl[2]  = mk(0, 8'h00, 0, 1, 8'h55, 1, 1,  0,  1,  1, 8'h55, 1, 1, 2);
    tbl[3]  = mk(1, 8'h11, 1, 1, 8'h21, 1, 1,  1,  0,  1, 8'h11, 1, 0, 3);
    tbl[4]  = mk(1, 8'h12, 1, 1, 8'h21, 1, 1,  0,  1,  1, 8'h21, 1, 1, 4);
    tbl[5]  = mk(1, 8'h12, 1, 1, 8'h22, 1, 1,  1,  0,  1, 8'h12, 1, 0, 5);
    tbl[6]  = mk(1, 8'h13, 1, 1, 8'h22, 1, 1,  0,  1,  1, 8'h22, 1, 1, 6);
    tbl[7]  = mk(0, 8'h00, 0, 1, 8'hA1, 0, 1,  0,  1,  1, 8'hA1, 0, 1, 6);
    tbl[8]  = mk(1, 8'h13, 1, 1, 8'hA2, 0, 1,  0,  1,  1, 8'hA2, 0, 1, 6);
    tbl[9]  = mk(1, 8'h13, 1, 1, 8'hA3, 1, 1,  0,  1,  1, 8'hA3, 1, 1, 7);
    tbl[10] = mk(1, 8'h13, 1, 0, 8'h00, 0, 1,  1,  0,  1, 8'h13, 1, 0, 8);
    tbl[11] = mk(1, 8'h40, 0, 0, 8'h00, 0, 0,  0,  0,  1, 8'h13, 1, 0, 8);
    tbl[12] = mk(1, 8'h40, 0, 0, 8'h00, 0, 0,  0,  0,  1, 8'h13, 1, 0, 8);
    tbl[13] = mk(1, 8'h40, 0, 0, 8'h00, 0, 0,  0,  0,  1, 8'h13, 1, 0, 8);
    tbl[14] = mk(1, 8'h40, 0, 0, 8'h00, 0, 1,  1,  0,  1, 8'h40, 0, 0, 8);
    tbl[15] = mk(1, 8'h41, 1, 1, 8'h77, 1, 1,  1,  0,  1, 8'h41, 1, 0, 9);
    tbl[16] = mk(0, 8'h00, 0, 1, 8'h77, 1, 1,  0,  1,  1, 8'h77, 1, 1, 10);
    tbl[17] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1,  0,  0,  0, 8'h77, 1, 1, 10);
    tbl[18] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0,  0,  0,  0, 8'h77, 1, 1, 10);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(tbl[i].v0, tbl[i].d0, tbl[i].l0, tbl[i].v1, tbl[i].d1, tbl[i].l1, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_rdy0", i), in0_ready, tbl[i].r0);
      chk($sformatf("tbl%0d_rdy1", i), in1_ready, tbl[i].r1);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_od", i), out_data, tbl[i].od);
      chk($sformatf("tbl%0d_ol", i), out_last, tbl[i].ol);
      chk($sformatf("tbl%0d_os", i), out_src, tbl[i].os);
      chk($sformatf("tbl%0d_cnt", i), pkt_cnt, tbl[i].cnt);
    end

    // Reset in the middle of a 4-beat ch0 packet.
    @(negedge clk);
    drive(1'b1, 8'hB0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'hB1, 1'b0, 1'b1, 8'h99, 1'b1, 1'b1);
    #1;
    chk("midrst_locked_rdy1", in1_ready, 0);
    @(posedge clk);
    #1;
    chk("midrst_od_b1", out_data, 8'hB1);
    @(negedge clk);
    drive(1'b1, 8'hB2, 1'b0, 1'b1, 8'h99, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ov", out_valid, 0);
    chk("midrst_cnt", pkt_cnt, 0);
    chk("midrst_rdy0", in0_ready, 0);
    chk("midrst_rdy1", in1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'hC0, 1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
    #1;
    chk("postrst_rdy0", in0_ready, 1);
    chk("postrst_rdy1", in1_ready, 0);
    @(posedge clk);
    #1;
    chk("postrst_od", out_data, 8'hC0);
    chk("postrst_os", out_src, 0);
    chk("postrst_cnt", pkt_cnt, 1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Counter wrap on the CNT_W=4 instance.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      w0_valid = 1'b1; w0_data = 8'(k); w0_last = 1'b1;
      @(posedge clk);
      #1;
      if (k == 15) chk("wrap_cnt16", w_pkt_cnt, 0);
    end
    @(negedge clk);
    w0_valid = 1'b0;
    #1;
    chk("wrap_cnt17", w_pkt_cnt, 1);
    chk("wrap_od", w_out_data, 8'd16);

    // Randomized run against the reference model.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_owner = -1; m_rr = 1'b1; m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_os = 1'b0; m_cnt = '0;
    for (int c = 0; c < 2; c++) begin
      pv[c] = 1'b0; pd[c] = '0; pl[c] = 1'b0; prem[c] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic ordy, load_ok, acc0, acc1;
      int g;
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (!pv[c] && $urandom_range(0, 99) < 60) begin
          if (prem[c] == 0) prem[c] = $urandom_range(1, 4);
          pv[c] = 1'b1;
          pd[c] = 8'($urandom);
          pl[c] = (prem[c] == 1);
        end
      end
      ordy = ($urandom_range(0, 99) < 70);
      drive(pv[0], pd[0], pl[0], pv[1], pd[1], pl[1], ordy);
      #1;
      chk("rnd_ov", out_valid, m_ov);
      if (m_ov) begin
        chk("rnd_od", out_data, m_od);
        chk("rnd_ol", out_last, m_ol);
        chk("rnd_os", out_src, m_os);
      end
      chk("rnd_cnt", pkt_cnt, m_cnt);
      load_ok = !m_ov || ordy;
      if (m_owner >= 0) g = m_owner;
      else if (pv[0] && pv[1]) g = m_rr ? 0 : 1;
      else if (pv[0]) g = 0;
      else if (pv[1]) g = 1;
      else g = -1;
      acc0 = load_ok && (g == 0);
      acc1 = load_ok && (g == 1);
      chk("rnd_rdy0", in0_ready, acc0);
      chk("rnd_rdy1", in1_ready, acc1);
      if ((acc0 && pv[0]) || (acc1 && pv[1])) begin
        m_ov = 1'b1; m_od = pd[g]; m_ol = pl[g]; m_os = g[0];
        if (pl[g]) begin
          m_owner = -1; m_rr = g[0]; m_cnt = m_cnt + 16'd1;
        end else begin
          m_owner = g;
        end
        prem[g] = prem[g] - 1;
        pv[g] = 1'b0;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
